multicycle_ctrl_fsm: RTL and testbench

- Control sequencer for the multicycle variant of the RV32I core; replaces the single-cycle combinational Control_Unit.
- Walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over one shared memory port with a req/ready handshake.
- Drives datapath enables and mux selects, plus the ALU operation code.
- Sits beside the datapath.

---
 rtl/mc_ctrl_pkg.sv | 63 ++++++
 rtl/multicycle_ctrl_fsm_if.sv | 11 +
 rtl/mc_alu_decoder.sv | 28 ++
 rtl/multicycle_ctrl_fsm.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control sequencer.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // Registered Moore control word, one per state.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       jal_pc_write;
        logic       reg_write;
        logic       retire;
        logic       illegal;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [3:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Shared memory-port handshake between the control sequencer and memory.
interface multicycle_ctrl_fsm_if;

    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);

endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational funct3/funct7b5 to ALU operation decode for R and I-ALU ops.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [3:0] aluop,
    output logic       illegal_funct
);

    always_comb begin
        aluop         = ALU_ADD;
        illegal_funct = 1'b0;
        case (funct3)
            3'b000: aluop = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: aluop = ALU_SLL;
            3'b010: aluop = ALU_SLT;
            3'b011: illegal_funct = 1'b1;
            3'b100: aluop = ALU_XOR;
            3'b101: aluop = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: aluop = ALU_OR;
            3'b111: aluop = ALU_AND;
            default: illegal_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control sequencer over a single shared memory port.
// Define PERF_CNT_EN to add the cycle_cnt / instret_cnt performance counters.
module multicycle_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned RESET_PC_HOLD = 0
)
(
    input  logic                         clk,
    input  logic                         rst,
    multicycle_ctrl_fsm_if.master        mem,
    input  logic [6:0]                   opcode,
    input  logic [2:0]                   funct3,
    input  logic                         funct7b5,
    input  logic                         zero_flag,
    output logic                         adr_src,
    output logic                         ir_write,
    output logic                         pc_write,
    output logic                         reg_write,
    output logic [1:0]                   alu_src_a,
    output logic [1:0]                   alu_src_b,
    output logic [1:0]                   result_src,
    output logic [3:0]                   aluop,
    output logic                         instr_retired,
    output logic                         illegal
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]                  cycle_cnt,
    output logic [31:0]                  instret_cnt
`endif
);

    localparam logic [3:0] HOLD_INIT = 4'(RESET_PC_HOLD);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] hold_cnt;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl_d;
    logic [3:0] dec_aluop;
    logic       dec_illegal;
    logic       mem_done;

    mc_alu_decoder u_alu_dec (
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .is_rtype      (opcode == OP_R),
        .aluop         (dec_aluop),
        .illegal_funct (dec_illegal)
    );

    // mem_ready only counts while a request is actually outstanding.
    assign mem_done = ctrl_q.mem_req & mem.mem_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (mem_done) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = dec_illegal ? S_TRAP : S_EXECR;
                    OP_I:         state_nxt = dec_illegal ? S_TRAP : S_EXECI;
                    OP_BRANCH:    state_nxt = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                    OP_JAL:       state_nxt = S_JAL;
                    default:      state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_done) state_nxt = S_MEMWB;
            S_MEMWR:  if (mem_done) state_nxt = S_FETCH;
            S_EXECR, S_EXECI, S_JAL: state_nxt = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH: state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_TRAP;
        endcase
    end

    // Control word is computed for the state being entered so outputs are registered.
    always_comb begin
        ctrl_d = '0;
        case (state_nxt)
            S_FETCH: begin
                ctrl_d.mem_req    = (hold_cnt == '0);
                ctrl_d.alu_src_a  = SRCA_PC;
                ctrl_d.alu_src_b  = SRCB_FOUR;
                ctrl_d.aluop      = ALU_ADD;
                ctrl_d.result_src = RES_ALU;
            end
            S_DECODE: begin
                ctrl_d.alu_src_a = SRCA_OLDPC;
                ctrl_d.alu_src_b = SRCB_IMM;
                ctrl_d.aluop     = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl_d.alu_src_a = SRCA_RS1;
                ctrl_d.alu_src_b = SRCB_IMM;
                ctrl_d.aluop     = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl_d.mem_req    = 1'b1;
                ctrl_d.adr_src    = 1'b1;
                ctrl_d.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl_d.result_src = RES_MEMDATA;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.retire     = 1'b1;
            end
            S_MEMWR: begin
                ctrl_d.mem_req = 1'b1;
                ctrl_d.mem_we  = 1'b1;
                ctrl_d.adr_src = 1'b1;
            end
            S_EXECR: begin
                ctrl_d.alu_src_a = SRCA_RS1;
                ctrl_d.alu_src_b = SRCB_RS2;
                ctrl_d.aluop     = dec_aluop;
            end
            S_EXECI: begin
                ctrl_d.alu_src_a = SRCA_RS1;
                ctrl_d.alu_src_b = SRCB_IMM;
                ctrl_d.aluop     = dec_aluop;
            end
            S_ALUWB: begin
                ctrl_d.result_src = RES_ALUOUT;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.retire     = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a  = SRCA_RS1;
                ctrl_d.alu_src_b  = SRCB_RS2;
                ctrl_d.aluop      = ALU_SUB;
                ctrl_d.result_src = RES_ALUOUT;
                ctrl_d.retire     = 1'b1;
            end
            S_JAL: begin
                ctrl_d.alu_src_a    = SRCA_OLDPC;
                ctrl_d.alu_src_b    = SRCB_FOUR;
                ctrl_d.aluop        = ALU_ADD;
                ctrl_d.result_src   = RES_ALUOUT;
                ctrl_d.jal_pc_write = 1'b1;
            end
            S_TRAP:  ctrl_d.illegal = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            hold_cnt <= HOLD_INIT;
            ctrl_q   <= '0;
        end else begin
            state  <= state_nxt;
            ctrl_q <= ctrl_d;
            if (state == S_FETCH && hold_cnt != '0)
                hold_cnt <= hold_cnt - 4'd1;
        end
    end

    assign mem.mem_req    = ctrl_q.mem_req;
    assign mem.mem_we     = ctrl_q.mem_we;
    assign adr_src        = ctrl_q.adr_src;
    assign reg_write      = ctrl_q.reg_write;
    assign alu_src_a      = ctrl_q.alu_src_a;
    assign alu_src_b      = ctrl_q.alu_src_b;
    assign result_src     = ctrl_q.result_src;
    assign aluop          = ctrl_q.aluop;
    assign illegal        = ctrl_q.illegal;
    assign ir_write       = (state == S_FETCH) & mem_done;
    assign pc_write       = ir_write | ctrl_q.jal_pc_write
                          | ((state == S_BRANCH) & (zero_flag ^ funct3[0]));
    assign instr_retired  = ctrl_q.retire | ((state == S_MEMWR) & mem_done);

`ifdef PERF_CNT_EN
    // The first cycle after reset carries no request, so it is not counted.
    logic counting;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counting    <= 1'b0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            counting <= 1'b1;
            if (counting && state != S_TRAP)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_retired && state != S_TRAP)
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed, table-driven bench for the multicycle control sequencer.
module tb_multicycle_ctrl_fsm;

    localparam int unsigned HOLD   = 2;
    localparam int unsigned NVEC   = 18;
    localparam int unsigned MAXCYC = 24;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        zf;
        int unsigned cycles;
        logic [3:0]  alu3;
        int unsigned regw;
        int unsigned pcw;
        int unsigned req;
        int unsigned we;
        logic [1:0]  rs_last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero_flag;
    logic        adr_src, ir_write, pc_write, reg_write, instr_retired, illegal;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [3:0]  aluop;
    logic [17:0] all_outs;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    vec_t        vecs [NVEC];
    logic        tr_req  [1:MAXCYC];
    logic        tr_adr  [1:MAXCYC];
    logic        tr_regw [1:MAXCYC];
    logic        tr_irw  [1:MAXCYC];

    multicycle_ctrl_fsm_if mem_bus ();

    multicycle_ctrl_fsm #(.RESET_PC_HOLD(HOLD)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem           (mem_bus),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero_flag     (zero_flag),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .aluop         (aluop),
        .instr_retired (instr_retired),
        .illegal       (illegal)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign all_outs = {mem_bus.mem_req, mem_bus.mem_we, adr_src, ir_write, pc_write, reg_write,
                       alu_src_a, alu_src_b, result_src, aluop, instr_retired, illegal};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Holds reset, releases it, and checks the request-free cycles that precede the first fetch.
    task automatic do_reset();
        rst = 1'b0;
        mem_bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int unsigned i = 0; i <= HOLD; i++) begin
            @(negedge clk);
            check($sformatf("dead%0d mem_req", i), 32'(mem_bus.mem_req), 0);
            check($sformatf("dead%0d ir_write", i), 32'(ir_write), 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic zf, input logic [31:0] ready_mask,
                             output int unsigned cyc, output logic [3:0] alu3,
                             output int unsigned regw, output int unsigned pcw,
                             output int unsigned req, output int unsigned we,
                             output logic [1:0] rs_last);
        bit done = 1'b0;
        opcode = op; funct3 = f3; funct7b5 = f7; zero_flag = zf;
        cyc = 0; alu3 = '0; regw = 0; pcw = 0; req = 0; we = 0; rs_last = '1;
        while (!done && cyc < MAXCYC) begin
            mem_bus.mem_ready = ready_mask[cyc];
            @(negedge clk);
            cyc++;
            tr_req[cyc]  = mem_bus.mem_req;
            tr_adr[cyc]  = adr_src;
            tr_regw[cyc] = reg_write;
            tr_irw[cyc]  = ir_write;
            if (cyc == 3) alu3 = aluop;
            if (reg_write) regw++;
            if (pc_write) pcw++;
            if (mem_bus.mem_req) req++;
            if (mem_bus.mem_we) we++;
            if (instr_retired) begin
                done = 1'b1;
                rs_last = result_src;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_vec(input vec_t v);
        int unsigned cyc, regw, pcw, req, we;
        logic [3:0]  a3;
        logic [1:0]  rs;
        run_instr(v.op, v.f3, v.f7, v.zf, '1, cyc, a3, regw, pcw, req, we, rs);
        check({v.name, " cycles"}, cyc, v.cycles);
        check({v.name, " aluop@3"}, 32'(a3), 32'(v.alu3));
        check({v.name, " reg_write"}, regw, v.regw);
        check({v.name, " pc_write"}, pcw, v.pcw);
        check({v.name, " mem_req"}, req, v.req);
        check({v.name, " mem_we"}, we, v.we);
        check({v.name, " result_src@retire"}, 32'(rs), 32'(v.rs_last));
    endtask

    task automatic trap_run(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input int unsigned ncyc);
        int unsigned bad = 0;
`ifdef PERF_CNT_EN
        logic [31:0] cyc_at_trap;
        cyc_at_trap = '0;
`endif
        opcode = op; funct3 = f3; funct7b5 = f7; zero_flag = 1'b1;
        mem_bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check({name, " decode illegal"}, 32'(illegal), 0);
        @(posedge clk);
        #1;
        for (int unsigned c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check({name, " illegal"}, 32'(illegal), 1);
`ifdef PERF_CNT_EN
                cyc_at_trap = cycle_cnt;
`endif
            end
            if (!illegal || pc_write || reg_write || mem_bus.mem_req || mem_bus.mem_we || instr_retired)
                bad++;
            @(posedge clk);
            #1;
        end
        check({name, " trap quiet"}, bad, 0);
`ifdef PERF_CNT_EN
        check({name, " cycle_cnt frozen"}, cycle_cnt, cyc_at_trap);
`endif
    endtask

    initial begin
        int unsigned cyc, regw, pcw, req, we;
        logic [3:0]  a3;
        logic [1:0]  rs;

        rst = 1'b0; opcode = '0; funct3 = '0; funct7b5 = 1'b0; zero_flag = 1'b0;
        mem_bus.mem_ready = 1'b0;

        //           name        op          f3      f7    zf    cyc alu3     rw pcw req we rs
        vecs[0]  = '{"addi",     7'b0010011, 3'b000, 1'b0, 1'b0, 4, 4'b0010, 1, 1, 1, 0, 2'b00};
        vecs[1]  = '{"addi_f7",  7'b0010011, 3'b000, 1'b1, 1'b0, 4, 4'b0010, 1, 1, 1, 0, 2'b00};
        vecs[2]  = '{"slti",     7'b0010011, 3'b010, 1'b0, 1'b0, 4, 4'b0111, 1, 1, 1, 0, 2'b00};
        vecs[3]  = '{"srli",     7'b0010011, 3'b101, 1'b0, 1'b0, 4, 4'b1001, 1, 1, 1, 0, 2'b00};
        vecs[4]  = '{"srai",     7'b0010011, 3'b101, 1'b1, 1'b0, 4, 4'b1010, 1, 1, 1, 0, 2'b00};
        vecs[5]  = '{"slli",     7'b0010011, 3'b001, 1'b0, 1'b0, 4, 4'b1000, 1, 1, 1, 0, 2'b00};
        vecs[6]  = '{"add",      7'b0110011, 3'b000, 1'b0, 1'b0, 4, 4'b0010, 1, 1, 1, 0, 2'b00};
        vecs[7]  = '{"sub",      7'b0110011, 3'b000, 1'b1, 1'b0, 4, 4'b0110, 1, 1, 1, 0, 2'b00};
        vecs[8]  = '{"and",      7'b0110011, 3'b111, 1'b0, 1'b0, 4, 4'b0000, 1, 1, 1, 0, 2'b00};
        vecs[9]  = '{"or",       7'b0110011, 3'b110, 1'b0, 1'b0, 4, 4'b0001, 1, 1, 1, 0, 2'b00};
        vecs[10] = '{"xor",      7'b0110011, 3'b100, 1'b0, 1'b0, 4, 4'b0011, 1, 1, 1, 0, 2'b00};
        vecs[11] = '{"lw",       7'b0000011, 3'b010, 1'b0, 1'b0, 5, 4'b0010, 1, 1, 2, 0, 2'b01};
        vecs[12] = '{"sw",       7'b0100011, 3'b010, 1'b0, 1'b0, 4, 4'b0010, 0, 1, 2, 1, 2'b00};
        vecs[13] = '{"beq_z1",   7'b1100011, 3'b000, 1'b0, 1'b1, 3, 4'b0110, 0, 2, 1, 0, 2'b00};
        vecs[14] = '{"bne_z1",   7'b1100011, 3'b001, 1'b0, 1'b1, 3, 4'b0110, 0, 1, 1, 0, 2'b00};
        vecs[15] = '{"beq_z0",   7'b1100011, 3'b000, 1'b0, 1'b0, 3, 4'b0110, 0, 1, 1, 0, 2'b00};
        vecs[16] = '{"bne_z0",   7'b1100011, 3'b001, 1'b0, 1'b0, 3, 4'b0110, 0, 2, 1, 0, 2'b00};
        vecs[17] = '{"jal",      7'b1101111, 3'b000, 1'b0, 1'b0, 4, 4'b0010, 1, 2, 1, 0, 2'b00};

        #3;
        check("reset outputs", 32'(all_outs), 0);
        do_reset();

        for (int unsigned i = 0; i < NVEC; i++)
            apply_vec(vecs[i]);

        // addi: write-back only in the fourth cycle
        run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, '1, cyc, a3, regw, pcw, req, we, rs);
        check("addi reg_write cycles", 32'({tr_regw[1], tr_regw[2], tr_regw[3], tr_regw[4]}), 32'b0001);

        // fetch stalled one cycle
        run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, ~32'h1, cyc, a3, regw, pcw, req, we, rs);
        check("stall fetch cycles", cyc, 5);
        check("stall fetch ir_write", 32'({tr_irw[1], tr_irw[2]}), 32'b01);
        check("stall fetch mem_req", 32'({tr_req[1], tr_req[2]}), 32'b11);

        // lw with two wait cycles in MEMRD
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, ~(32'h3 << 3), cyc, a3, regw, pcw, req, we, rs);
        check("lw wait cycles", cyc, 7);
        for (int unsigned c = 4; c <= 6; c++) begin
            check($sformatf("lw wait c%0d mem_req", c), 32'(tr_req[c]), 1);
            check($sformatf("lw wait c%0d adr_src", c), 32'(tr_adr[c]), 1);
        end
        check("lw wait reg_write c7", 32'(tr_regw[7]), 1);
        check("lw wait reg_write count", regw, 1);
        check("lw wait result_src", 32'(rs), 32'b01);

        // reset in the middle of MEMRD
        opcode = 7'b0000011; funct3 = 3'b010; mem_bus.mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mem_bus.mem_ready = 1'b0;
        @(negedge clk);
        check("memrd mem_req", 32'(mem_bus.mem_req), 1);
        check("memrd adr_src", 32'(adr_src), 1);
        #2 rst = 1'b0;
        #1 check("async reset outputs", 32'(all_outs), 0);
        do_reset();
        run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, '1, cyc, a3, regw, pcw, req, we, rs);
        check("post-reset first mem_req", 32'(tr_req[1]), 1);
        check("post-reset first ir_write", 32'(tr_irw[1]), 1);
        check("post-reset addi cycles", cyc, 4);

`ifdef PERF_CNT_EN
        do_reset();
        check("perf cycle_cnt start", cycle_cnt, HOLD);
        check("perf instret_cnt start", instret_cnt, 0);
        repeat (3) run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, '1, cyc, a3, regw, pcw, req, we, rs);
        check("perf instret_cnt", instret_cnt, 3);
        check("perf cycle_cnt", cycle_cnt, 12 + HOLD);
`endif

        do_reset();
        trap_run("op7f", 7'h7F, 3'b000, 1'b0, 100);
        rst = 1'b0;
        #1 check("trap cleared by reset", 32'(illegal), 0);
        do_reset();
        trap_run("branch f3=010", 7'b1100011, 3'b010, 1'b0, 3);
        do_reset();
        trap_run("sltu", 7'b0110011, 3'b011, 1'b0, 3);
        do_reset();
        trap_run("sltiu", 7'b0010011, 3'b011, 1'b0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
